// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: game phase encodings and line-clear scoring.
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_PLAY    = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_OVER    = 3'd4
  } game_state_e;

  function automatic logic [3:0] line_points(input logic [2:0] n);
    case (n)
      3'd1:    line_points = 4'd1;
      3'd2:    line_points = 4'd3;
      3'd3:    line_points = 4'd5;
      3'd4:    line_points = 4'd8;
      default: line_points = 4'd0;
    endcase
  endfunction

  function automatic logic lines_legal(input logic [2:0] n);
    return (n != 3'd0) && (n <= 3'd4);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Key events and bitmap status in, game-phase control out.
interface game_sequencer_if #(
  parameter int LEVEL_W = 3,
  parameter int SCORE_W = 10
);
  logic               pressed_pause_or_start;
  logic               pressed_speed_up_down;
  logic               lines_valid;
  logic [2:0]         lines_cleared;
  logic               game_over_in;
  logic               falling_update;
  logic               board_clr;
  logic               game_run;
  logic [2:0]         game_state;
  logic               fast_mode;
  logic [LEVEL_W-1:0] level;
  logic [SCORE_W-1:0] game_score;

  modport master (
    output pressed_pause_or_start, pressed_speed_up_down, lines_valid, lines_cleared, game_over_in,
    input  falling_update, board_clr, game_run, game_state, fast_mode, level, game_score
  );

  modport slave (
    input  pressed_pause_or_start, pressed_speed_up_down, lines_valid, lines_cleared, game_over_in,
    output falling_update, board_clr, game_run, game_state, fast_mode, level, game_score
  );
endinterface

// File: rtl/game_sequencer_fall_tick_gen.sv
// Fall tick generator: period shrinks with level and fast mode, never below 2 cycles.
module fall_tick_gen #(
  parameter int SPEED_FREQ = 50_000_000,
  parameter int LEVEL_W    = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               clear,
  input  logic [LEVEL_W-1:0] level,
  input  logic               fast_mode,
  output logic               falling_update
);
  localparam int CNT_W = $clog2(SPEED_FREQ) + 1;
  localparam logic [CNT_W-1:0] SPEED_C = CNT_W'(SPEED_FREQ);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] shifted_s;
  logic [CNT_W-1:0] period_s;
  logic             fire_s;
  logic             tick_r;

  // Current period and wrap detect; >= lets a shrunken period fire at once.
  always_comb begin
    shifted_s = (SPEED_C >> level) >> fast_mode;
    period_s  = (shifted_s < CNT_W'(2)) ? CNT_W'(2) : shifted_s;
    fire_s    = (cnt_r >= (period_s - CNT_W'(1)));
  end

  // Tick counter; holds whenever enable is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (enable) begin
      if (fire_s) begin
        cnt_r  <= '0;
        tick_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        tick_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign falling_update = tick_r;
endmodule

// File: rtl/game_sequencer.sv
// Tetris game-phase controller: run state, restart sequencing, score and level.
module game_sequencer
  import tetris_pkg::*;
#(
  parameter int SPEED_FREQ      = 50_000_000,
  parameter int LEVEL_W         = 3,
  parameter int SCORE_W         = 10,
  parameter int LINES_PER_LEVEL = 10
) (
  input logic            clk,
  input logic            rstn,
  game_sequencer_if.slave bus
);
  localparam int LC_W = $clog2(LINES_PER_LEVEL + 4);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  game_state_e        state_r;
  game_state_e        next_state_s;
  logic               board_clr_r;
  logic               game_run_r;
  logic               fast_r;
  logic [LEVEL_W-1:0] level_r;
  logic [SCORE_W-1:0] score_r;
  logic [LC_W-1:0]    lines_r;
  logic               in_game_s;
  logic               credit_s;
  logic [SCORE_W:0]   score_sum_s;
  logic [LC_W-1:0]    lines_sum_s;
  logic               tick_en_s;
  logic               tick_clr_s;
  logic               tick_s;

  // Next phase plus score/line arithmetic for the current event.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:    if (bus.pressed_pause_or_start) next_state_s = ST_RESTART; else next_state_s = ST_IDLE;
      ST_RESTART: next_state_s = ST_PLAY;
      ST_PLAY: begin
        if (bus.game_over_in)                next_state_s = ST_OVER;
        else if (bus.pressed_pause_or_start) next_state_s = ST_PAUSE;
        else                                 next_state_s = ST_PLAY;
      end
      ST_PAUSE:   if (bus.pressed_pause_or_start) next_state_s = ST_PLAY; else next_state_s = ST_PAUSE;
      ST_OVER:    if (bus.pressed_pause_or_start) next_state_s = ST_RESTART; else next_state_s = ST_OVER;
      default:    next_state_s = ST_IDLE;
    endcase
    in_game_s   = (state_r == ST_PLAY) || (state_r == ST_PAUSE);
    credit_s    = bus.lines_valid && in_game_s && lines_legal(bus.lines_cleared);
    score_sum_s = {1'b0, score_r} + {{(SCORE_W-3){1'b0}}, line_points(bus.lines_cleared)};
    lines_sum_s = lines_r + LC_W'(bus.lines_cleared);
    // Counting the cycle being entered keeps the counter frozen across a pause.
    tick_en_s   = (next_state_s == ST_PLAY);
    tick_clr_s  = (state_r == ST_RESTART) || (next_state_s == ST_RESTART);
  end

  // Phase register and game statistics; restart clears on entry so RESTART already shows zeros.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      board_clr_r <= 1'b0;
      game_run_r  <= 1'b0;
      fast_r      <= 1'b0;
      level_r     <= '0;
      score_r     <= '0;
      lines_r     <= '0;
    end else begin
      state_r     <= next_state_s;
      board_clr_r <= (next_state_s == ST_RESTART);
      game_run_r  <= (next_state_s == ST_PLAY);
      if (next_state_s == ST_RESTART) begin
        fast_r  <= 1'b0;
        level_r <= '0;
        score_r <= '0;
        lines_r <= '0;
      end else begin
        if (bus.pressed_speed_up_down && in_game_s) fast_r <= ~fast_r;
        if (credit_s) begin
          score_r <= (score_sum_s > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum_s[SCORE_W-1:0];
          if (lines_sum_s >= LC_W'(LINES_PER_LEVEL)) begin
            lines_r <= lines_sum_s - LC_W'(LINES_PER_LEVEL);
            if (level_r != LEVEL_MAX) level_r <= level_r + LEVEL_W'(1);
          end else begin
            lines_r <= lines_sum_s;
          end
        end
      end
    end
  end

  fall_tick_gen #(
    .SPEED_FREQ(SPEED_FREQ),
    .LEVEL_W   (LEVEL_W)
  ) u_tick (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (tick_en_s),
    .clear         (tick_clr_s),
    .level         (level_r),
    .fast_mode     (fast_r),
    .falling_update(tick_s)
  );

  assign bus.falling_update = tick_s;
  assign bus.board_clr      = board_clr_r;
  assign bus.game_run       = game_run_r;
  assign bus.game_state     = state_r;
  assign bus.fast_mode      = fast_r;
  assign bus.level          = level_r;
  assign bus.game_score     = score_r;
endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: tick scoreboard, score table, phase corner cases.
module tb_game_sequencer;
  import tetris_pkg::*;

  typedef struct {
    logic [2:0] lines;
    int         exp_score;
    int         exp_level;
  } score_vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  game_sequencer_if #(.LEVEL_W(3), .SCORE_W(10)) bus1 ();
  game_sequencer_if #(.LEVEL_W(3), .SCORE_W(4))  bus2 ();

  game_sequencer #(.SPEED_FREQ(16), .LEVEL_W(3), .SCORE_W(10), .LINES_PER_LEVEL(10)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1));
  game_sequencer #(.SPEED_FREQ(16), .LEVEL_W(3), .SCORE_W(4), .LINES_PER_LEVEL(4)) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2));

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         tick_q[$];
  bit         tick_en = 1'b0;
  score_vec_t sb_q[$];
  score_vec_t vecs[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Tick scoreboard for dut1: every observed tick must match the next expected cycle.
  always @(posedge clk) begin
    #1;
    if (tick_en && bus1.falling_update === 1'b1) begin
      if (tick_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick: tick seen at cycle %0d, none expected", cyc);
      end else begin
        chk("tick_cycle", cyc, tick_q.pop_front());
      end
    end
  end

  task automatic close_ticks(input string nm);
    chk(nm, tick_q.size(), 0);
    tick_q.delete();
    tick_en = 1'b0;
  endtask

  task automatic press_ps1;
    bus1.pressed_pause_or_start = 1'b1;
    @(negedge clk);
    bus1.pressed_pause_or_start = 1'b0;
  endtask

  task automatic press_sp1;
    bus1.pressed_speed_up_down = 1'b1;
    @(negedge clk);
    bus1.pressed_speed_up_down = 1'b0;
  endtask

  task automatic lines1(input logic [2:0] n, input int es, input int el, input string nm);
    score_vec_t v;
    v.lines = n; v.exp_score = es; v.exp_level = el;
    sb_q.push_back(v);
    bus1.lines_valid = 1'b1;
    bus1.lines_cleared = n;
    @(negedge clk);
    bus1.lines_valid = 1'b0;
    bus1.lines_cleared = 3'd0;
    v = sb_q.pop_front();
    chk({nm, "_score"}, 32'(bus1.game_score), v.exp_score);
    chk({nm, "_level"}, 32'(bus1.level), v.exp_level);
  endtask

  task automatic lines2(input logic [2:0] n, input int es, input int el);
    bus2.lines_valid = 1'b1;
    bus2.lines_cleared = n;
    @(negedge clk);
    bus2.lines_valid = 1'b0;
    bus2.lines_cleared = 3'd0;
    chk("sat_score", 32'(bus2.game_score), es);
    chk("sat_level", 32'(bus2.level), el);
  endtask

  initial begin
    int  s;
    int  t;
    int  r;
    bit  found;

    vecs[0] = '{3'd4, 8, 0};   vecs[1] = '{3'd1, 9, 0};
    vecs[2] = '{3'd3, 14, 0};  vecs[3] = '{3'd2, 17, 1};
    vecs[4] = '{3'd0, 17, 1};  vecs[5] = '{3'd5, 17, 1};
    vecs[6] = '{3'd4, 25, 1};  vecs[7] = '{3'd4, 33, 1};
    vecs[8] = '{3'd1, 34, 1};  vecs[9] = '{3'd1, 35, 2};

    rstn = 1'b0;
    bus1.pressed_pause_or_start = 1'b0; bus1.pressed_speed_up_down = 1'b0;
    bus1.lines_valid = 1'b0; bus1.lines_cleared = 3'd0; bus1.game_over_in = 1'b0;
    bus2.pressed_pause_or_start = 1'b0; bus2.pressed_speed_up_down = 1'b0;
    bus2.lines_valid = 1'b0; bus2.lines_cleared = 3'd0; bus2.game_over_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus1.game_state), 32'(ST_IDLE));
    chk("rst_board_clr", 32'(bus1.board_clr), 0);
    chk("rst_run", 32'(bus1.game_run), 0);
    chk("rst_tick", 32'(bus1.falling_update), 0);
    chk("rst_fast", 32'(bus1.fast_mode), 0);
    chk("rst_level", 32'(bus1.level), 0);
    chk("rst_score", 32'(bus1.game_score), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Events in IDLE are ignored.
    press_sp1();
    chk("idle_fast", 32'(bus1.fast_mode), 0);
    lines1(3'd4, 0, 0, "idle_lines");

    // Startup: one board_clr cycle, then PLAY with 16-cycle ticks.
    press_ps1();
    chk("start_clr", 32'(bus1.board_clr), 1);
    chk("start_restart", 32'(bus1.game_state), 32'(ST_RESTART));
    chk("start_run_lo", 32'(bus1.game_run), 0);
    @(negedge clk);
    chk("start_clr_lo", 32'(bus1.board_clr), 0);
    chk("start_play", 32'(bus1.game_state), 32'(ST_PLAY));
    chk("start_run", 32'(bus1.game_run), 1);
    s = cyc;
    tick_q.push_back(s + 16); tick_q.push_back(s + 32); tick_q.push_back(s + 48);
    tick_en = 1'b1;
    repeat (48) @(negedge clk);

    // Fast mode: ticks every 8 cycles, pressed right on a tick.
    t = cyc;
    tick_q.push_back(t + 8); tick_q.push_back(t + 16); tick_q.push_back(t + 24);
    press_sp1();
    chk("fast_on", 32'(bus1.fast_mode), 1);
    repeat (23) @(negedge clk);

    // Pause 3 cycles after a tick: 100 silent cycles, then 5 cycles to the next tick.
    repeat (3) @(negedge clk);
    press_ps1();
    chk("pause_state", 32'(bus1.game_state), 32'(ST_PAUSE));
    chk("pause_run", 32'(bus1.game_run), 0);
    repeat (100) @(negedge clk);
    r = cyc;
    tick_q.push_back(r + 5); tick_q.push_back(r + 13);
    press_ps1();
    chk("resume_state", 32'(bus1.game_state), 32'(ST_PLAY));
    repeat (12) @(negedge clk);
    close_ticks("missed_ticks_fast");
    press_sp1();
    chk("fast_off", 32'(bus1.fast_mode), 0);

    // Scoring table including illegal counts.
    for (int i = 0; i < 6; i++) lines1(vecs[i].lines, vecs[i].exp_score, vecs[i].exp_level, "score_tbl");

    // Level 1 at normal speed gives period 8.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus1.falling_update === 1'b1) found = 1'b1;
    end
    chk("lvl1_tick_found", 32'(found), 1);
    if (found) begin
      t = cyc;
      tick_q.push_back(t + 8); tick_q.push_back(t + 16);
      tick_en = 1'b1;
      repeat (16) @(negedge clk);
      close_ticks("missed_ticks_lvl1");
    end

    // Line counter restarted at 0 after the level step: next level needs exactly 10 more.
    for (int i = 6; i < 10; i++) lines1(vecs[i].lines, vecs[i].exp_score, vecs[i].exp_level, "score_tbl");

    // Game over wins over a simultaneous press; OVER ignores lines and speed.
    press_sp1();
    chk("fast_before_over", 32'(bus1.fast_mode), 1);
    bus1.game_over_in = 1'b1;
    bus1.pressed_pause_or_start = 1'b1;
    @(negedge clk);
    bus1.game_over_in = 1'b0;
    bus1.pressed_pause_or_start = 1'b0;
    chk("over_prio", 32'(bus1.game_state), 32'(ST_OVER));
    chk("over_run", 32'(bus1.game_run), 0);
    lines1(3'd4, 35, 2, "over_lines");
    press_sp1();
    chk("over_fast_hold", 32'(bus1.fast_mode), 1);
    press_ps1();
    chk("restart_clr", 32'(bus1.board_clr), 1);
    chk("restart_state", 32'(bus1.game_state), 32'(ST_RESTART));
    chk("restart_score", 32'(bus1.game_score), 0);
    chk("restart_level", 32'(bus1.level), 0);
    chk("restart_fast", 32'(bus1.fast_mode), 0);
    @(negedge clk);
    chk("restart_play", 32'(bus1.game_state), 32'(ST_PLAY));
    chk("restart_clr_lo", 32'(bus1.board_clr), 0);
    lines1(3'd1, 1, 0, "replay");

    // Asynchronous reset mid-game.
    rstn = 1'b0;
    #1;
    chk("midrst_state", 32'(bus1.game_state), 32'(ST_IDLE));
    chk("midrst_score", 32'(bus1.game_score), 0);
    chk("midrst_clr", 32'(bus1.board_clr), 0);
    chk("midrst_run", 32'(bus1.game_run), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Second instance: 4-bit score saturation, level clamp at 7, period clamp at 2.
    bus2.pressed_pause_or_start = 1'b1;
    @(negedge clk);
    bus2.pressed_pause_or_start = 1'b0;
    @(negedge clk);
    chk("d2_play", 32'(bus2.game_state), 32'(ST_PLAY));
    for (int k = 1; k <= 8; k++) lines2(3'd4, (8 * k > 15) ? 15 : 8 * k, (k > 7) ? 7 : k);
    bus2.pressed_speed_up_down = 1'b1;
    @(negedge clk);
    bus2.pressed_speed_up_down = 1'b0;
    chk("d2_fast", 32'(bus2.fast_mode), 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus2.falling_update === 1'b1) found = 1'b1;
    end
    chk("d2_tick_found", 32'(found), 1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("d2_period2", 32'(bus2.falling_update), (i % 2 == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
